// File: rtl/uart_cmd_parser.sv
// Framed UART command parser (SYNC, CMD, ARG, CHK) driving per-channel PWM brightness registers.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | hunting for SYNC_BYTE, other bytes ignored
// GOT_SYNC | sync seen, next byte is CMD
// GOT_CMD  | CMD latched, next byte is ARG
// GOT_ARG  | ARG latched, next byte is CHK (execute/reject)
module uart_cmd_parser #(
  parameter int          NUM_CH         = 4,
  parameter logic [7:0]  INIT_BRIGHT    = 8'h40,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 12000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_CH*8-1:0] bright,
  output logic [NUM_CH-1:0]   bright_upd,
  output logic                frame_ok,
  output logic                frame_err
);

  typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_CMD, GOT_ARG} state_t;

  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_cmd_parser: parameter out of range");
  end

  state_t              state, state_nxt;
  logic [7:0]          cmd_q, cmd_nxt;
  logic [7:0]          arg_q, arg_nxt;
  logic [NUM_CH*8-1:0] bright_nxt;
  logic [NUM_CH-1:0]   upd_nxt;
  logic                ok_nxt, err_nxt;
  logic                chk_ok, op_ok, ch_ok;
  logic                tmo_hit;

  // Saturating per-channel arithmetic; the 9th bit is the carry/borrow.
  function automatic logic [7:0] apply_op(input logic [3:0] op, input logic [7:0] cur,
                                          input logic [7:0] arg);
    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] res;
    sum  = {1'b0, cur} + {1'b0, arg};
    diff = {1'b0, cur} - {1'b0, arg};
    case (op)
      4'h1:    res = sum[8]  ? 8'hFF : sum[7:0];
      4'h2:    res = diff[8] ? 8'h00 : diff[7:0];
      default: res = arg;
    endcase
    return res;
  endfunction

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign tmo_hit = (state != IDLE) && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || rx_valid || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign chk_ok = (rx_data == (cmd_q ^ arg_q));
  assign op_ok  = (cmd_q[7:4] <= 4'h2);
  assign ch_ok  = ({28'd0, cmd_q[3:0]} < 32'(NUM_CH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      arg_q      <= '0;
      bright     <= {NUM_CH{INIT_BRIGHT}};
      bright_upd <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cmd_q      <= cmd_nxt;
      arg_q      <= arg_nxt;
      bright     <= bright_nxt;
      bright_upd <= upd_nxt;
      frame_ok   <= ok_nxt;
      frame_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd_q;
    arg_nxt    = arg_q;
    bright_nxt = bright;
    upd_nxt    = '0;
    ok_nxt     = 1'b0;
    err_nxt    = 1'b0;
    if (tmo_hit) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_nxt = GOT_SYNC;
        end
        GOT_SYNC: begin
          cmd_nxt   = rx_data;
          state_nxt = GOT_CMD;
        end
        GOT_CMD: begin
          arg_nxt   = rx_data;
          state_nxt = GOT_ARG;
        end
        GOT_ARG: begin
          state_nxt = IDLE;
          if (chk_ok && cmd_q == 8'hF0) begin
            bright_nxt = {NUM_CH{arg_q}};
            upd_nxt    = '1;
            ok_nxt     = 1'b1;
          end else if (chk_ok && op_ok && ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (cmd_q[3:0] == 4'(i)) begin
                bright_nxt[8*i +: 8] = apply_op(cmd_q[7:4], bright[8*i +: 8], arg_q);
                upd_nxt[i]           = 1'b1;
              end
            end
            ok_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed frames plus randomized traffic against a frame-level model.
// Defining UART_CMD_TIMEOUT_EN also runs the timeout scenario with a 50-cycle timeout.
module tb_uart_cmd_parser;
  localparam int NUM_CH = 4;
  localparam int TMO    = 50;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [NUM_CH*8-1:0] bright;
  logic [NUM_CH-1:0]   bright_upd;
  logic                frame_ok;
  logic                frame_err;

  int tests = 0;
  int fails = 0;

  // Reference model state: byte collection queue and expected outputs.
  logic [7:0]          m_q[$];
  logic [NUM_CH*8-1:0] m_bright;
  logic [NUM_CH-1:0]   m_upd;
  logic                m_ok;
  logic                m_err;

  uart_cmd_parser #(
    .NUM_CH(NUM_CH), .INIT_BRIGHT(8'h40), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .bright(bright), .bright_upd(bright_upd), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_q.delete();
    m_bright = {NUM_CH{8'h40}};
    m_upd    = '0;
    m_ok     = 1'b0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_exec(input logic [7:0] cmd, input logic [7:0] arg,
                                     input logic [7:0] chk);
    int n, cur, a, nv;
    a = int'(arg);
    if (chk != (cmd ^ arg)) begin
      m_err = 1'b1;
    end else if (cmd == 8'hF0) begin
      m_bright = {NUM_CH{arg}};
      m_upd    = '1;
      m_ok     = 1'b1;
    end else begin
      n = int'(cmd[3:0]);
      if (int'(cmd[7:4]) > 2 || n >= NUM_CH) begin
        m_err = 1'b1;
      end else begin
        cur = int'(m_bright[8*n +: 8]);
        case (int'(cmd[7:4]))
          0:       nv = a;
          1:       nv = (cur + a > 255) ? 255 : cur + a;
          default: nv = (cur - a < 0) ? 0 : cur - a;
        endcase
        m_bright[8*n +: 8] = nv[7:0];
        m_upd[n]           = 1'b1;
        m_ok               = 1'b1;
      end
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    m_ok  = 1'b0;
    m_err = 1'b0;
    m_upd = '0;
    if (m_q.size() == 0) begin
      if (b == 8'hA5) m_q.push_back(b);
    end else begin
      m_q.push_back(b);
      if (m_q.size() == 4) begin
        model_exec(m_q[1], m_q[2], m_q[3]);
        m_q.delete();
      end
    end
  endfunction

  // Called at a negedge; returns at the next negedge with outputs of the sampling edge visible.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    model_byte(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    m_ok  = 1'b0;
    m_err = 1'b0;
    m_upd = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    apply_reset(3);
    for (int c = 0; c < 100; c++) begin
      tests++;
      if (bright !== {NUM_CH{8'h40}} || bright_upd !== '0 || frame_ok !== 1'b0 ||
          frame_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: bright=%h upd=%b ok=%b err=%b, want 40404040/0/0/0",
                 c, bright, bright_upd, frame_ok, frame_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_set;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h80); send_byte(8'h82);
    tests++;
    if (bright !== 32'h4080_4040 || bright_upd !== 4'b0100 || frame_ok !== 1'b1 ||
        frame_err !== 1'b0) begin
      fails++;
      $display("FAIL set_ch2: bright=%h upd=%b ok=%b err=%b, want 40804040/0100/1/0",
               bright, bright_upd, frame_ok, frame_err);
    end
    idle(1);
    tests++;
    if (bright_upd !== '0 || frame_ok !== 1'b0 || bright !== m_bright) begin
      fails++;
      $display("FAIL strobe_clear: upd=%b ok=%b bright=%h, want 0/0/%h",
               bright_upd, frame_ok, bright, m_bright);
    end
  endtask

  task automatic test_saturate;
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'hF0); send_byte(8'hE1);
    tests++;
    if (bright[15:8] !== 8'hFF || bright_upd !== 4'b0010 || frame_ok !== 1'b1) begin
      fails++;
      $display("FAIL inc_sat: ch1=%h upd=%b ok=%b, want ff/0010/1", bright[15:8], bright_upd,
               frame_ok);
    end
    idle(2);
    send_byte(8'hA5); send_byte(8'h21); send_byte(8'hFF); send_byte(8'hDE);
    tests++;
    if (bright[15:8] !== 8'h00 || bright_upd !== 4'b0010 || frame_ok !== 1'b1) begin
      fails++;
      $display("FAIL dec_sat: ch1=%h upd=%b ok=%b, want 00/0010/1", bright[15:8], bright_upd,
               frame_ok);
    end
    idle(1);
  endtask

  task automatic test_reject;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h80); send_byte(8'h83);
    tests++;
    if (frame_err !== 1'b1 || frame_ok !== 1'b0 || bright_upd !== '0 ||
        bright[23:16] !== 8'h80) begin
      fails++;
      $display("FAIL bad_chk: err=%b ok=%b upd=%b ch2=%h, want 1/0/0/80", frame_err, frame_ok,
               bright_upd, bright[23:16]);
    end
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h10); send_byte(8'h17);
    tests++;
    if (frame_err !== 1'b1 || frame_ok !== 1'b0 || bright_upd !== '0 || bright !== m_bright) begin
      fails++;
      $display("FAIL bad_chan: err=%b ok=%b upd=%b bright=%h, want 1/0/0/%h", frame_err,
               frame_ok, bright_upd, bright, m_bright);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq[6];
    seq = '{8'h00, 8'hFF, 8'hA5, 8'hF0, 8'h20, 8'hD0};
    for (int k = 0; k < 6; k++) begin
      send_byte(seq[k]);
      if (k < 5) begin
        tests++;
        if (frame_err !== 1'b0 || frame_ok !== 1'b0) begin
          fails++;
          $display("FAIL b2b_byte%0d: err=%b ok=%b, want 0/0", k, frame_err, frame_ok);
        end
      end
    end
    tests++;
    if (bright !== 32'h2020_2020 || bright_upd !== 4'b1111 || frame_ok !== 1'b1 ||
        frame_err !== 1'b0) begin
      fails++;
      $display("FAIL setall: bright=%h upd=%b ok=%b err=%b, want 20202020/1111/1/0", bright,
               bright_upd, frame_ok, frame_err);
    end
    idle(1);
  endtask

  task automatic test_reset_midframe;
    send_byte(8'hA5);
    send_byte(8'h01);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (frame_err !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_err cycle %0d: err=%b, want 0", c, frame_err);
      end
    end
    rst_n = 1'b1;
    model_reset();
    idle(2);
    tests++;
    if (bright !== {NUM_CH{8'h40}} || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_state: bright=%h err=%b, want 40404040/0", bright, frame_err);
    end
    // The discarded partial frame must not swallow the bytes of the next one.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h33); send_byte(8'h33);
    tests++;
    if (bright[7:0] !== 8'h33 || frame_ok !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_next: ch0=%h ok=%b, want 33/1", bright[7:0], frame_ok);
    end
    idle(1);
  endtask

  task automatic test_random;
    for (int f = 0; f < 200; f++) begin
      logic [7:0] fr[4];
      logic [7:0] cmd, arg, chk, stray;
      int kind;
      kind = $urandom_range(0, 19);
      if (kind < 12)      cmd = {4'($urandom_range(0, 2)), 4'($urandom_range(0, NUM_CH - 1))};
      else if (kind < 14) cmd = 8'hF0;
      else if (kind < 17) cmd = 8'($urandom);
      else                cmd = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      arg = 8'($urandom);
      chk = cmd ^ arg;
      if ($urandom_range(0, 6) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
      fr = '{8'hA5, cmd, arg, chk};
      if ($urandom_range(0, 4) == 0) begin
        stray = 8'($urandom);
        if (stray == 8'hA5) stray = 8'h5A;
        send_byte(stray);
        tests++;
        if (frame_err !== 1'b0 || frame_ok !== 1'b0) begin
          fails++;
          $display("FAIL rand_stray f%0d: err=%b ok=%b, want 0/0", f, frame_err, frame_ok);
        end
      end
      for (int k = 0; k < 4; k++) begin
        send_byte(fr[k]);
        tests++;
        if (bright !== m_bright || bright_upd !== m_upd || frame_ok !== m_ok ||
            frame_err !== m_err) begin
          fails++;
          $display("FAIL rand f%0d b%0d (%h %h %h %h): bright=%h upd=%b ok=%b err=%b, want %h/%b/%b/%b",
                   f, k, fr[0], fr[1], fr[2], fr[3], bright, bright_upd, frame_ok, frame_err,
                   m_bright, m_upd, m_ok, m_err);
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(1);
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout;
    int pulses, first;
    pulses = 0;
    first  = -1;
    send_byte(8'hA5);
    send_byte(8'h03);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    m_q.delete();
    tests++;
    if (pulses != 1 || first < TMO - 1 || first > TMO + 2) begin
      fails++;
      $display("FAIL timeout_pulse: pulses=%0d at cycle %0d, want 1 near cycle %0d", pulses,
               first, TMO);
    end
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h12);
    tests++;
    if (bright[31:24] !== 8'h11 || frame_ok !== 1'b1) begin
      fails++;
      $display("FAIL timeout_recover: ch3=%h ok=%b, want 11/1", bright[31:24], frame_ok);
    end
    idle(1);
    send_byte(8'hA5);
    rst_n = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      tests++;
      if (frame_err !== 1'b0) begin
        fails++;
        $display("FAIL timeout_rst cycle %0d: err=%b, want 0", c, frame_err);
      end
    end
    model_reset();
    tests++;
    if (bright !== {NUM_CH{8'h40}}) begin
      fails++;
      $display("FAIL timeout_rst_bright: bright=%h, want 40404040", bright);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_set();
    test_saturate();
    test_reject();
    test_back_to_back();
    test_reset_midframe();
    test_random();
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits between the UART byte receiver and the PWM LED drivers.
- Consumes the validated byte stream (data plus one-cycle valid strobe) and assembles fixed 4-byte command frames. It checks each frame's checksum, then writes per-channel 8-bit brightness registers that drive the PWM stages.
- Replaces "raw byte = brightness" with a framed, error-checked protocol that supports multiple LED channels.

Parameters:
- NUM_CH, 4, number of brightness channels (1..16).
- INIT_BRIGHT, 8'h40, reset value of every channel register.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 12000, inter-byte timeout in CLK cycles (1 ms at 12 MHz). Used only with UART_CMD_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock (12 MHz).
- RST_N  input  1  synchronous active-low reset.
- RX_DATA  input  8  received byte, valid only when RX_VALID=1.
- RX_VALID  input  1  single-cycle strobe, one per received byte.
- BRIGHT  output  NUM_CH*8  channel brightness registers; channel n occupies bits [8n+7:8n].
- BRIGHT_UPD  output  NUM_CH  one-cycle per-channel strobe, high when that channel's register was written.
- FRAME_OK  output  1  one-cycle pulse on a good frame that was executed.
- FRAME_ERR  output  1  one-cycle pulse on a rejected frame (checksum, bad command, timeout).

Behaviour:
- Reset (RST_N=0 sampled on a CLK edge):
  - state=IDLE;
  - every BRIGHT channel = INIT_BRIGHT;
  - BRIGHT_UPD, FRAME_OK, FRAME_ERR = 0;
  - cmd/arg holding registers = 0;
  - timeout counter = 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- Frame format: SYNC_BYTE, CMD, ARG, CHK, where CHK must equal CMD ^ ARG.
- FSM states: IDLE, GOT_SYNC, GOT_CMD, GOT_ARG. Transitions happen only on RX_VALID=1.
  - IDLE: byte==SYNC_BYTE -> GOT_SYNC. Any other byte is silently ignored (no error).
  - GOT_SYNC: latch CMD -> GOT_CMD. SYNC_BYTE here is treated as ordinary CMD data (no resync).
  - GOT_CMD: latch ARG -> GOT_ARG.
  - GOT_ARG: compare byte with CMD^ARG, execute or reject, -> IDLE.
- Commands (n = CMD[3:0]):
  - 8'h0n SET: ch[n] = ARG.
  - 8'h1n INC: ch[n] = min(ch[n]+ARG, 255). Use a 9-bit add, saturate on the carry.
  - 8'h2n DEC: ch[n] = max(ch[n]-ARG, 0). Use a 9-bit subtract, saturate on the borrow.
  - 8'hF0 SETALL: every channel = ARG; all BRIGHT_UPD bits high.
  - Any other CMD, or n >= NUM_CH -> reject.
- Latency: the edge that samples the CHK byte updates BRIGHT, BRIGHT_UPD and FRAME_OK/FRAME_ERR. They are visible the next cycle, exactly one cycle after RX_VALID.
  - Strobes clear automatically after one cycle.
  - BRIGHT_UPD fires even when the value does not change (e.g. INC at 255).
- Reject: no BRIGHT change, BRIGHT_UPD=0, FRAME_ERR=1 for one cycle. FRAME_OK and FRAME_ERR are never high together.
- Back-to-back frames with zero idle cycles between bytes must be accepted. RX_VALID may be high on consecutive cycles.
- Bytes never arrive faster than once per cycle. No backpressure exists; the block must always accept.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs while state != IDLE and is cleared on every accepted byte and in IDLE.
  - When it reaches TIMEOUT_CYCLES with no RX_VALID, state -> IDLE and FRAME_ERR pulses once.
  - If RX_VALID coincides with the terminal count, the byte wins: it is processed and there is no timeout.
  - Counter width = $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter logic; a partial frame waits indefinitely.

Test Plan:
- Reset release, no input -> all BRIGHT channels = 8'h40, all strobes 0 for 100 cycles.
- Bytes A5,02,80,82 -> cycle after the CHK byte: ch2=8'h80, BRIGHT_UPD=4'b0100, FRAME_OK=1; other channels stay 8'h40.
- Bytes A5,11,F0,E1 with ch1=8'h40 -> ch1=8'hFF (saturated), FRAME_OK=1. Then A5,21,FF,DE -> ch1=8'h00.
- Bytes A5,02,80,83 (bad CHK) -> FRAME_ERR=1, ch2 unchanged. Then A5,07,10,17 with NUM_CH=4 -> FRAME_ERR=1, no update.
- Stray bytes 00,FF then A5,F0,20,D0 back-to-back on consecutive cycles -> no error for the stray bytes, all channels = 8'h20, BRIGHT_UPD=4'b1111.
- UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=50: send A5,03, wait 60 cycles -> FRAME_ERR once at cycle 50, then full frame A5,03,11,12 -> ch3=8'h11. Assert RST_N=0 after A5 -> no error pulse, channels = 8'h40.
